// File: rtl/num_unbuilder_if.sv
// rtl/num_unbuilder_if.sv - request and token-stream bundle for the numeric token serialiser
interface num_unbuilder_if #(
    parameter int width    = 8,
    parameter int newWidth = 44
);
    logic                start;
    logic [newWidth-1:0] resultIn;
    logic                busy;
    logic                tokValid;
    logic                tokReady;
    logic [width-1:0]    tokData;
    logic                tokLast;
    logic                done;

    // Requester / token consumer side
    modport master (
        output start, resultIn, tokReady,
        input  busy, tokValid, tokData, tokLast, done
    );

    // Serialiser side
    modport slave (
        input  start, resultIn, tokReady,
        output busy, tokValid, tokData, tokLast, done
    );
endinterface

// File: rtl/num_unbuilder.sv
// rtl/num_unbuilder.sv - serialises a numeric token into MSD-first key-code tokens
module num_unbuilder #(
    parameter int width    = 8,
    parameter int newWidth = 44,
    parameter int digits   = 12
) (
    input  logic            clock,
    input  logic            reset,
    num_unbuilder_if.slave  bus
);
    localparam int mantWidth = newWidth - 6;
    localparam int cntWidth  = $clog2(mantWidth);
    localparam int idxWidth  = $clog2(digits);

    typedef enum logic [2:0] {
        IDLE,
        CONV,
        SCAN,
        EMIT,
        ERR,
        DONE
    } state_t;

    state_t state, stateNext;

    logic [mantWidth-1:0] mant;
    logic [3:0]           expo;
    logic                 sign;
    logic [4*digits-1:0]  bcd;
    logic [4*digits-1:0]  bcdNext;
    logic [cntWidth-1:0]  bitCount;
    logic [idxWidth-1:0]  cur;
    logic                 signPend;
    logic                 pointPend;

    logic [idxWidth-1:0]  msd;
    logic [idxWidth-1:0]  top;
    logic [idxWidth-1:0]  expIdx;
    logic [3:0]           curDigit;
    logic                 lastTok;
    logic                 accept;
    logic                 startBad;

    logic                 busyInt;
    logic                 validInt;
    logic [width-1:0]     dataInt;
    logic                 lastInt;
    logic                 doneInt;

    assign expIdx   = idxWidth'(expo);
    assign curDigit = bcd[4*cur +: 4];
    // The current digit is the final token once no sign or point is pending ahead of digit 0.
    assign lastTok  = !signPend && !pointPend && (cur == '0);
    assign accept   = validInt && bus.tokReady;
    // Non-number tags and more decimal places than digits cannot be printed.
    assign startBad = !bus.resultIn[newWidth-1] ||
                      (bus.resultIn[newWidth-3 -: 4] > 4'(digits - 1));
    assign top      = (msd > expIdx) ? msd : expIdx;

    assign bus.busy     = busyInt;
    assign bus.tokValid = validInt;
    assign bus.tokData  = dataInt;
    assign bus.tokLast  = lastInt;
    assign bus.done     = doneInt;

    // One double-dabble step: add 3 to every digit >= 5, then shift in the next mantissa bit.
    always_comb begin
        logic [3:0] d;
        bcdNext    = '0;
        bcdNext[0] = mant[mantWidth-1];
        for (int i = 0; i < digits; i++) begin
            d = bcd[4*i +: 4];
            if (d >= 4'd5) begin
                d = d + 4'd3;
            end
            if (i < digits - 1) begin
                bcdNext[4*i+1 +: 4] = d;
            end else begin
                bcdNext[4*i+1 +: 3] = d[2:0];
            end
        end
    end

    // Index of the highest non-zero BCD digit, 0 when the value is zero.
    always_comb begin
        msd = '0;
        for (int i = 0; i < digits; i++) begin
            if (bcd[4*i +: 4] != 4'd0) begin
                msd = idxWidth'(i);
            end
        end
    end

    // State register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state decode and stream outputs, all derived from registered state so they hold during stalls.
    always_comb begin
        stateNext = state;
        busyInt   = 1'b0;
        validInt  = 1'b0;
        dataInt   = '0;
        lastInt   = 1'b0;
        doneInt   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    stateNext = startBad ? ERR : CONV;
                end
            end
            CONV: begin
                busyInt = 1'b1;
                if (bitCount == cntWidth'(mantWidth - 1)) begin
                    stateNext = SCAN;
                end
            end
            SCAN: begin
                busyInt   = 1'b1;
                stateNext = EMIT;
            end
            EMIT: begin
                busyInt  = 1'b1;
                validInt = 1'b1;
                if (signPend) begin
                    dataInt = width'(11);
                end else if (pointPend) begin
                    dataInt = width'(16);
                end else begin
                    dataInt = width'(curDigit);
                end
                lastInt = lastTok;
                if (accept && lastTok) begin
                    stateNext = DONE;
                end
            end
            ERR: begin
                busyInt  = 1'b1;
                validInt = 1'b1;
                dataInt  = width'(8'hEE);
                lastInt  = 1'b1;
                if (accept) begin
                    stateNext = DONE;
                end
            end
            DONE: begin
                busyInt   = 1'b1;
                doneInt   = 1'b1;
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Datapath: capture, binary-to-BCD shifting, emit pointer setup and advance on each accepted token.
    always_ff @(posedge clock) begin
        if (!reset) begin
            mant      <= '0;
            expo      <= '0;
            sign      <= 1'b0;
            bcd       <= '0;
            bitCount  <= '0;
            cur       <= '0;
            signPend  <= 1'b0;
            pointPend <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        mant     <= bus.resultIn[mantWidth-1:0];
                        expo     <= bus.resultIn[newWidth-3 -: 4];
                        sign     <= bus.resultIn[newWidth-2];
                        bcd      <= '0;
                        bitCount <= '0;
                    end
                end
                CONV: begin
                    bcd      <= bcdNext;
                    mant     <= {mant[mantWidth-2:0], 1'b0};
                    bitCount <= bitCount + 1'b1;
                end
                SCAN: begin
                    // A zero mantissa leaves every BCD digit zero, so no '-' for negative zero.
                    cur       <= top;
                    signPend  <= sign && (bcd != '0);
                    pointPend <= 1'b0;
                end
                EMIT: begin
                    if (accept) begin
                        if (signPend) begin
                            signPend <= 1'b0;
                        end else if (pointPend) begin
                            pointPend <= 1'b0;
                            cur       <= cur - 1'b1;
                        end else if (cur != '0) begin
                            // The point follows digit[exp]; hold the index until the point is sent.
                            if ((cur == expIdx) && (expo != 4'd0)) begin
                                pointPend <= 1'b1;
                            end else begin
                                cur <= cur - 1'b1;
                            end
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_num_unbuilder.sv
// tb/tb_num_unbuilder.sv - randomized self-checking bench for num_unbuilder
module tb_num_unbuilder;
    logic clock;
    logic reset;

    num_unbuilder_if #(.width(8), .newWidth(44)) bus ();

    num_unbuilder #(.width(8), .newWidth(44), .digits(12)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int nChecks = 0;
    int nFail   = 0;

    logic [8:0] expQ[$];
    logic [8:0] rstGot[$];
    logic [43:0] w1;
    int          rstCnt;
    int          rstEdges;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        nChecks++;
        if (got !== want) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic logic [43:0] mk(input bit tg, input bit sg, input int ex, input logic [37:0] m);
        return {tg, sg, 4'(ex), m};
    endfunction

    // Expected tokens from the decimal text of the mantissa, padded and punctuated.
    function automatic void model(input logic [43:0] w);
        logic [37:0] m;
        int          ex;
        string       s;
        logic [8:0]  t;
        m  = w[37:0];
        ex = int'(w[41:38]);
        expQ.delete();
        if (!w[43] || ex > 11) begin
            expQ.push_back({1'b1, 8'hEE});
            return;
        end
        s = $sformatf("%0d", m);
        while (s.len() < ex + 1) s = {"0", s};
        if (w[42] && m != 0) expQ.push_back({1'b0, 8'd11});
        for (int i = 0; i < s.len(); i++) begin
            expQ.push_back({1'b0, 8'(s[i] - 8'd48)});
            if (ex != 0 && i == s.len() - 1 - ex) expQ.push_back({1'b0, 8'd16});
        end
        t = expQ.pop_back();
        t[8] = 1'b1;
        expQ.push_back(t);
    endfunction

    task automatic run(input logic [43:0] w, input bit rnd, input bit poke);
        logic [8:0] got[$];
        logic [8:0] held;
        int         edges;
        int         wantLat;
        bit         seen;
        bit         stalled;
        bit         fin;
        model(w);
        wantLat = (!w[43] || w[41:38] > 4'd11) ? 1 : 40;
        @(negedge clock);
        bus.resultIn = w;
        bus.start    = 1'b1;
        bus.tokReady = 1'b0;
        @(negedge clock);
        bus.start = 1'b0;
        check("busy_after_start", bus.busy, 1);
        edges   = 0;
        seen    = 0;
        stalled = 0;
        fin     = 0;
        held    = '0;
        while (!fin && edges < 600) begin
            if (stalled) begin
                check("stall_valid", bus.tokValid, 1);
                check("stall_hold", {bus.tokLast, bus.tokData}, held);
            end
            if (bus.tokValid && !seen) begin
                seen = 1;
                check("first_latency", edges + 1, wantLat);
            end
            check("no_early_done", bus.done, 0);
            if (poke && edges == 5) begin
                bus.start    = 1'b1;
                bus.resultIn = ~w;
            end else begin
                bus.start = 1'b0;
            end
            bus.tokReady = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            stalled = bus.tokValid && !bus.tokReady;
            held    = {bus.tokLast, bus.tokData};
            if (bus.tokValid && bus.tokReady) begin
                got.push_back({bus.tokLast, bus.tokData});
                if (bus.tokLast) fin = 1;
            end
            @(negedge clock);
            edges++;
        end
        bus.start    = 1'b0;
        bus.tokReady = 1'b0;
        check("stream_finished", fin, 1);
        check("done_pulse", bus.done, 1);
        check("busy_in_done", bus.busy, 1);
        @(negedge clock);
        check("done_cleared", bus.done, 0);
        check("busy_cleared", bus.busy, 0);
        check("token_count", got.size(), expQ.size());
        for (int i = 0; i < expQ.size(); i++) begin
            if (i < got.size()) check($sformatf("tok%0d", i), got[i], expQ[i]);
        end
    endtask

    initial begin
        reset        = 1'b0;
        bus.start    = 1'b0;
        bus.resultIn = '0;
        bus.tokReady = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_busy", bus.busy, 0);
        check("rst_valid", bus.tokValid, 0);
        check("rst_last", bus.tokLast, 0);
        check("rst_done", bus.done, 0);
        check("rst_data", bus.tokData, 0);
        reset = 1'b1;

        run(mk(1, 0, 4, 38'd832341), 0, 0);
        run(mk(1, 1, 3, 38'd5), 0, 0);
        run(mk(1, 1, 0, 38'd0), 0, 0);
        run(mk(1, 0, 2, 38'd0), 0, 0);
        run(mk(1, 0, 0, 38'h3F_FFFF_FFFF), 1, 0);
        run(mk(0, 0, 0, 38'd123), 0, 0);
        run(mk(1, 0, 12, 38'd7), 1, 0);
        run(mk(1, 1, 5, 38'd9876543), 1, 1);

        // Reset in the middle of the token stream.
        w1 = mk(1, 0, 4, 38'd832341);
        model(w1);
        @(negedge clock);
        bus.resultIn = w1;
        bus.start    = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        rstCnt    = 0;
        rstEdges  = 0;
        rstGot.delete();
        while (rstCnt < 3 && rstEdges < 200) begin
            bus.tokReady = 1'b1;
            if (bus.tokValid) begin
                rstGot.push_back({bus.tokLast, bus.tokData});
                rstCnt++;
            end
            @(negedge clock);
            rstEdges++;
        end
        check("rst_pre_count", rstCnt, 3);
        for (int i = 0; i < 3; i++) begin
            if (i < rstGot.size()) check($sformatf("rst_pre_tok%0d", i), rstGot[i], expQ[i]);
        end
        reset = 1'b0;
        @(negedge clock);
        check("mid_rst_valid", bus.tokValid, 0);
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_done", bus.done, 0);
        check("mid_rst_data", bus.tokData, 0);
        check("mid_rst_last", bus.tokLast, 0);
        bus.start    = 1'b1;
        bus.resultIn = w1;
        @(negedge clock);
        bus.start = 1'b0;
        check("rst_start_ignored", bus.busy, 0);
        check("rst_no_done", bus.done, 0);
        reset        = 1'b1;
        bus.tokReady = 1'b0;
        @(negedge clock);
        check("idle_after_rst", bus.busy, 0);
        run(w1, 1, 0);

        // Randomized mix of magnitudes, exponents, signs and tags.
        for (int n = 0; n < 25; n++) begin
            logic [37:0] m;
            int          ex;
            bit          tg;
            logic [43:0] w;
            case ($urandom_range(0, 3))
                0: m = 38'({$urandom(), $urandom()});
                1: m = 38'($urandom_range(0, 999));
                2: m = 38'd0;
                default: m = 38'($urandom());
            endcase
            ex = int'($urandom_range(0, 13));
            tg = ($urandom_range(0, 9) != 0);
            w  = mk(tg, 1'($urandom_range(0, 1)), ex, m);
            run(w, 1'($urandom_range(0, 1)), tg && ex <= 11 && ($urandom_range(0, 1) == 1));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end
endmodule
